snake_body_sequencer: RTL and testbench

Owns the snake segment store and sequences one body advance per `update_snake` pulse from the game FSM: shift, then head write, then self-collision scan. It also shares the store's single read port with the VGA renderer, granting reads only when no update is in progress. Sits between the game FSM, the renderer and the collision logic.

---
 rtl/snake_body_sequencer_if.sv | 32 +++
 rtl/snake_body_sequencer.sv | 149 ++++++++++++++
 tb/tb_snake_body_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_body_sequencer_if.sv
// snake_body_sequencer_if: game FSM / renderer / collision signals around the segment store
interface snake_body_sequencer_if #(
  parameter int IDX_W = 5,
  parameter int X_W   = 6,
  parameter int Y_W   = 5
);
  logic             update_snake;
  logic             grow;
  logic             reset_game;
  logic [1:0]       direction;
  logic             rd_req;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_valid;
  logic [X_W-1:0]   rd_x;
  logic [Y_W-1:0]   rd_y;
  logic [X_W-1:0]   head_x;
  logic [Y_W-1:0]   head_y;
  logic [IDX_W:0]   length;
  logic             busy;
  logic             done;
  logic             wall_hit;
  logic             self_hit;
  logic             overrun;
  modport master (
    output update_snake, grow, reset_game, direction, rd_req, rd_idx,
    input  rd_valid, rd_x, rd_y, head_x, head_y, length, busy, done, wall_hit, self_hit, overrun
  );
  modport slave (
    input  update_snake, grow, reset_game, direction, rd_req, rd_idx,
    output rd_valid, rd_x, rd_y, head_x, head_y, length, busy, done, wall_hit, self_hit, overrun
  );
endinterface

// File: rtl/snake_body_sequencer.sv
// snake_body_sequencer: segment store sequencing shift, head write and self-collision scan per update
module snake_body_sequencer #(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int START_X  = 20,
  parameter int START_Y  = 15,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int IDX_W    = 5
) (
  input logic clk,
  input logic rstn,
  snake_body_sequencer_if.slave bus
);
  typedef enum logic [2:0] {INIT, IDLE, SHIFT, HEAD, CHECK} state_t;
  state_t           state_q;
  logic [IDX_W-1:0] i_q;
  logic [IDX_W:0]   len_q;
  logic [1:0]       dir_q;
  logic [X_W-1:0]   nx_q, rd_x_q;
  logic [Y_W-1:0]   ny_q, rd_y_q;
  logic             hit_q, rd_valid_q, done_q, wall_q, self_q, overrun_q;
  logic [X_W-1:0]   seg_x [MAX_LEN];
  logic [Y_W-1:0]   seg_y [MAX_LEN];
  logic [1:0]       dir_d;
  logic [X_W-1:0]   nx_d, wx;
  logic [Y_W-1:0]   ny_d, wy;
  logic [IDX_W:0]   len_d;
  logic [IDX_W-1:0] wa;
  logic             wall_d, hit_d, we, rd_ok, rd_in;

  // next-head geometry, store write port selection and read acceptance
  always_comb begin
    dir_d  = (bus.direction == (dir_q ^ 2'b10)) ? dir_q : bus.direction;
    nx_d   = dir_d == 2'b01 ? seg_x[0] + 1'b1 : dir_d == 2'b11 ? seg_x[0] - 1'b1 : seg_x[0];
    ny_d   = dir_d == 2'b10 ? seg_y[0] + 1'b1 : dir_d == 2'b00 ? seg_y[0] - 1'b1 : seg_y[0];
    wall_d = (dir_d == 2'b00 && seg_y[0] == '0) || (dir_d == 2'b01 && seg_x[0] == X_W'(GRID_W - 1)) ||
             (dir_d == 2'b10 && seg_y[0] == Y_W'(GRID_H - 1)) || (dir_d == 2'b11 && seg_x[0] == '0);
    len_d  = (bus.grow && len_q != (IDX_W+1)'(MAX_LEN)) ? len_q + 1'b1 : len_q;
    hit_d  = hit_q | (seg_x[0] == seg_x[i_q] && seg_y[0] == seg_y[i_q]);
    we     = !bus.reset_game && (state_q == INIT || state_q == SHIFT || state_q == HEAD);
    wa     = state_q == HEAD ? '0 : i_q;
    wx     = state_q == INIT ? X_W'(START_X) - X_W'(i_q) : state_q == SHIFT ? seg_x[i_q - 1'b1] : nx_q;
    wy     = state_q == INIT ? Y_W'(START_Y) : state_q == SHIFT ? seg_y[i_q - 1'b1] : ny_q;
    rd_ok  = state_q == IDLE && !bus.update_snake && bus.rd_req;
    rd_in  = {1'b0, bus.rd_idx} < len_q;
  end

  // segment store: initial pose, tail-first shift, then new head
  always_ff @(posedge clk) begin
    if (we) begin
      seg_x[wa] <= wx;
      seg_y[wa] <= wy;
    end
  end

  // update sequencer with registered status pulses and read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= INIT;
      i_q        <= '0;
      len_q      <= (IDX_W+1)'(INIT_LEN);
      dir_q      <= 2'b01;
      nx_q       <= '0;
      ny_q       <= '0;
      hit_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      done_q     <= 1'b0;
      wall_q     <= 1'b0;
      self_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      wall_q     <= 1'b0;
      self_q     <= 1'b0;
      rd_valid_q <= rd_ok;
      if (rd_ok) begin
        rd_x_q <= rd_in ? seg_x[bus.rd_idx] : '0;
        rd_y_q <= rd_in ? seg_y[bus.rd_idx] : '0;
      end
      if (bus.update_snake && state_q != IDLE) overrun_q <= 1'b1;
      if (bus.reset_game) begin
        state_q   <= INIT;
        i_q       <= '0;
        len_q     <= (IDX_W+1)'(INIT_LEN);
        dir_q     <= 2'b01;
        overrun_q <= 1'b0;
      end else begin
        case (state_q)
          INIT: begin
            i_q <= i_q + 1'b1;
            if (i_q == IDX_W'(INIT_LEN - 1)) state_q <= IDLE;
          end
          IDLE: begin
            if (bus.update_snake) begin
              dir_q <= dir_d;
              if (wall_d) begin
                done_q <= 1'b1;
                wall_q <= 1'b1;
              end else begin
                len_q   <= len_d;
                i_q     <= IDX_W'(len_d - 1'b1);
                nx_q    <= nx_d;
                ny_q    <= ny_d;
                state_q <= SHIFT;
              end
            end
          end
          SHIFT: begin
            i_q <= i_q - 1'b1;
            if (i_q == IDX_W'(1)) state_q <= HEAD;
          end
          HEAD: begin
            i_q     <= IDX_W'(1);
            hit_q   <= 1'b0;
            state_q <= CHECK;
          end
          CHECK: begin
            if ({1'b0, i_q} == len_q - 1'b1) begin
              done_q  <= 1'b1;
              self_q  <= hit_d;
              state_q <= IDLE;
            end else begin
              hit_q <= hit_d;
              i_q   <= i_q + 1'b1;
            end
          end
          default: state_q <= INIT;
        endcase
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_x     = rd_x_q;
  assign bus.rd_y     = rd_y_q;
  assign bus.head_x   = seg_x[0];
  assign bus.head_y   = seg_y[0];
  assign bus.length   = len_q;
  assign bus.busy     = state_q != IDLE;
  assign bus.done     = done_q;
  assign bus.wall_hit = wall_q;
  assign bus.self_hit = self_q;
  assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_snake_body_sequencer.sv
// tb_snake_body_sequencer: directed plus random stimulus against a queue-level snake model
module tb_snake_body_sequencer;
  localparam int MAX_LEN = 32, INIT_LEN = 3, GRID_W = 40, GRID_H = 30, SX = 20, SY = 15;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int errors = 0, checks = 0;
  snake_body_sequencer_if #(.IDX_W(5), .X_W(6), .Y_W(5)) bus();
  snake_body_sequencer dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // model: body as head-first array, mode 0 idle / 1 init / 2 moving with a countdown to done
  int m_mode, m_cnt, m_len, m_dir, m_rdx, m_rdy;
  bit m_over, m_done, m_wall, m_self, m_rdv, m_pself;
  int bx [MAX_LEN];
  int by [MAX_LEN];

  function automatic void restart();
    m_mode = 1; m_cnt = INIT_LEN; m_len = INIT_LEN; m_dir = 1; m_over = 0;
    for (int k = 0; k < MAX_LEN; k++) begin
      bx[k] = k < INIT_LEN ? SX - k : 0;
      by[k] = SY;
    end
  endfunction

  function automatic void step();
    int nd, nx, ny, l;
    bit hit;
    m_rdv = m_mode == 0 && !bus.update_snake && bus.rd_req;
    if (m_rdv) begin
      m_rdx = int'(bus.rd_idx) < m_len ? bx[bus.rd_idx] : 0;
      m_rdy = int'(bus.rd_idx) < m_len ? by[bus.rd_idx] : 0;
    end
    m_done = 0; m_wall = 0; m_self = 0;
    if (bus.update_snake && m_mode != 0) m_over = 1;
    if (bus.reset_game) restart();
    else if (m_mode == 1) begin
      m_cnt--;
      if (m_cnt == 0) m_mode = 0;
    end else if (m_mode == 2) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_mode = 0; m_done = 1; m_self = m_pself;
      end
    end else if (bus.update_snake) begin
      nd = int'(bus.direction) == (m_dir ^ 2) ? m_dir : int'(bus.direction);
      m_dir = nd;
      nx = bx[0] + (nd == 1 ? 1 : nd == 3 ? -1 : 0);
      ny = by[0] + (nd == 2 ? 1 : nd == 0 ? -1 : 0);
      if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
        m_done = 1; m_wall = 1;
      end else begin
        l = m_len + int'(bus.grow) > MAX_LEN ? MAX_LEN : m_len + int'(bus.grow);
        for (int k = l - 1; k > 0; k--) begin
          bx[k] = bx[k-1];
          by[k] = by[k-1];
        end
        bx[0] = nx; by[0] = ny;
        hit = 0;
        for (int k = 1; k < l; k++) hit |= bx[k] == nx && by[k] == ny;
        m_pself = hit; m_len = l; m_mode = 2; m_cnt = 2 * l - 1;
      end
    end
  endfunction

  // compare on the falling edge, then advance the model with the inputs the next rising edge will see
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      restart();
      m_done = 0; m_wall = 0; m_self = 0; m_rdv = 0;
    end
    chk("busy", bus.busy, m_mode != 0);
    chk("done", bus.done, m_done);
    chk("wall_hit", bus.wall_hit, m_wall);
    chk("self_hit", bus.self_hit, m_self);
    chk("rd_valid", bus.rd_valid, m_rdv);
    chk("overrun", bus.overrun, m_over);
    chk("length", bus.length, m_len);
    if (m_rdv && bus.rd_valid) begin
      chk("rd_x", bus.rd_x, m_rdx);
      chk("rd_y", bus.rd_y, m_rdy);
    end
    if (m_mode == 0) begin
      chk("head_x", bus.head_x, bx[0]);
      chk("head_y", bus.head_y, by[0]);
    end
    if (rstn) step();
  end

  task automatic pulse(int d, bit g);
    @(posedge clk); #1;
    bus.update_snake = 1'b1; bus.direction = 2'(d); bus.grow = g;
    @(posedge clk); #1;
    bus.update_snake = 1'b0; bus.grow = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int w, output int s);
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
    w = bus.wall_hit;
    s = bus.self_hit;
  endtask

  task automatic move(string nm, int d, bit g, int lat, int wall, int self);
    int cyc, w, s;
    pulse(d, g);
    wait_done(cyc, w, s);
    chk({nm, "_latency"}, cyc, lat);
    chk({nm, "_wall"}, w, wall);
    chk({nm, "_self"}, s, self);
  endtask

  task automatic rd(string nm, int idx, int ex, int ey);
    int n;
    @(posedge clk); #1;
    bus.rd_req = 1'b1; bus.rd_idx = 5'(idx);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.rd_valid && n < 100);
    bus.rd_req = 1'b0;
    chk({nm, "_x"}, bus.rd_x, ex);
    chk({nm, "_y"}, bus.rd_y, ey);
  endtask

  initial begin
    int n, dn, cyc, w, s;
    bus.update_snake = 0; bus.grow = 0; bus.reset_game = 0; bus.direction = 2'b01;
    bus.rd_req = 0; bus.rd_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1);
    chk("rst_len", bus.length, 3);
    chk("rst_done", bus.done, 0);
    rstn = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.busy && n < 50);
    chk("init_cycles", n, 3);
    rd("init0", 0, 20, 15);
    rd("init1", 1, 19, 15);
    rd("init2", 2, 18, 15);
    rd("beyond_len", 5, 0, 0);
    move("right", 1, 0, 6, 0, 0);
    rd("mv0", 0, 21, 15);
    rd("mv1", 1, 20, 15);
    rd("mv2", 2, 19, 15);
    move("grow", 1, 1, 8, 0, 0);
    chk("grow_len", bus.length, 4);
    rd("g0", 0, 22, 15);
    rd("g1", 1, 21, 15);
    rd("g2", 2, 20, 15);
    rd("g3", 3, 19, 15);
    move("rev1", 3, 0, 8, 0, 0);
    chk("rev1_x", bus.head_x, 23);
    move("rev2", 3, 0, 8, 0, 0);
    chk("rev2_x", bus.head_x, 24);
    move("grow5", 1, 1, 10, 0, 0);
    chk("len5", bus.length, 5);
    move("up", 0, 0, 10, 0, 0);
    move("left", 3, 0, 10, 0, 0);
    move("down", 2, 0, 10, 0, 1);
    chk("down_x", bus.head_x, 24);
    chk("down_y", bus.head_y, 15);
    chk("pre_overrun", bus.overrun, 0);
    pulse(2, 0);
    @(posedge clk); #1;
    bus.update_snake = 1'b1;
    @(posedge clk); #1;
    bus.update_snake = 1'b0;
    chk("overrun_set", bus.overrun, 1);
    wait_done(cyc, w, s);
    chk("overrun_sticky", bus.overrun, 1);
    chk("overrun_len", bus.length, 5);
    @(posedge clk); #1;
    bus.update_snake = 1'b1; bus.direction = 2'b10;
    @(posedge clk); #1;
    bus.update_snake = 1'b0;
    bus.rd_req = 1'b1; bus.rd_idx = '0;
    n = 1;
    while (!bus.rd_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    bus.rd_req = 1'b0;
    chk("busy_rd_lat", n, 11);
    chk("busy_rd_x", bus.rd_x, 24);
    chk("busy_rd_y", bus.rd_y, 17);
    pulse(2, 0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    bus.reset_game = 1'b1;
    dn = 0;
    repeat (2) begin
      @(posedge clk); #1;
      dn += int'(bus.done);
    end
    bus.reset_game = 1'b0;
    n = 0;
    while (bus.busy && n < 50) begin
      @(posedge clk); #1;
      dn += int'(bus.done);
      n++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_len", bus.length, 3);
    chk("abort_overrun", bus.overrun, 0);
    chk("abort_hx", bus.head_x, 20);
    chk("abort_hy", bus.head_y, 15);
    for (int k = 0; k < 19; k++) move("walk", 1, 0, 6, 0, 0);
    chk("walk_x", bus.head_x, 39);
    move("wall", 1, 0, 1, 1, 0);
    chk("wall_x", bus.head_x, 39);
    rd("wall1", 1, 38, 15);
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      bus.update_snake = $urandom_range(0, 5) == 0;
      bus.grow         = 1'($urandom_range(0, 1));
      bus.direction    = 2'($urandom_range(0, 3));
      bus.rd_req       = $urandom_range(0, 2) == 0;
      bus.rd_idx       = 5'($urandom_range(0, 9));
      bus.reset_game   = $urandom_range(0, 149) == 0;
    end
    bus.update_snake = 0; bus.rd_req = 0; bus.reset_game = 0;
    repeat (80) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
